// File: rtl/vote_tally_reporter.sv
// Snapshots four vote counters on request, resolves winner/tie, and streams a
// 7-byte result frame (header, counts, status, XOR checksum) over valid/ready.
module vote_tally_reporter #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] vc1,
  input  logic [7:0] vc2,
  input  logic [7:0] vc3,
  input  logic [7:0] vc4,
  input  logic       report_req,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [1:0] winner,
  output logic       tie,
  output logic       done,
  output logic       error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] LAST_BYTE = 3'd6;

  // Stall counter wide enough to hold TIMEOUT-1; abort fires on the stalled
  // edge that would bring the count to TIMEOUT.
  localparam int unsigned   SW          = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [3:0][7:0]  snap;
  logic [2:0]       idx;
  logic [SW-1:0]    stall_cnt;

  logic [7:0]       max_cnt;
  logic [1:0]       cmp_winner;
  logic [2:0]       n_max;
  logic             cmp_tie;
  logic [7:0]       status_byte;
  logic [7:0]       checksum;

  assign busy = (state != ST_IDLE);

  // Strict '>' keeps the lowest index among equal maxima.
  always_comb begin
    max_cnt    = snap[0];
    cmp_winner = 2'd0;
    n_max      = 3'd0;
    for (int i = 1; i < 4; i++) begin
      if (snap[i] > max_cnt) begin
        max_cnt    = snap[i];
        cmp_winner = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (snap[i] == max_cnt) n_max = n_max + 3'd1;
    end
    cmp_tie = (n_max > 3'd1);
  end

  assign status_byte = {tie, 5'b0, winner};
  assign checksum    = HEADER ^ snap[0] ^ snap[1] ^ snap[2] ^ snap[3] ^ status_byte;

  always_comb begin
    tx_data = 8'h00;
    if (state == ST_SEND) begin
      case (idx)
        3'd0:    tx_data = HEADER;
        3'd1:    tx_data = snap[0];
        3'd2:    tx_data = snap[1];
        3'd3:    tx_data = snap[2];
        3'd4:    tx_data = snap[3];
        3'd5:    tx_data = status_byte;
        default: tx_data = checksum;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the snapshot is reset too because it feeds tx_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      snap      <= '0;
      idx       <= 3'd0;
      stall_cnt <= '0;
      tx_valid  <= 1'b0;
      winner    <= 2'd0;
      tie       <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (report_req) begin
            snap  <= {vc4, vc3, vc2, vc1};
            state <= ST_CMP;
          end
        end
        ST_CMP: begin
          winner    <= cmp_winner;
          tie       <= cmp_tie;
          idx       <= 3'd0;
          stall_cnt <= '0;
          tx_valid  <= 1'b1;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_ready) begin
            stall_cnt <= '0;
            if (idx == LAST_BYTE) begin
              tx_valid <= 1'b0;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              idx <= idx + 3'd1;
            end
          end else if (TIMEOUT != 0 && stall_cnt == STALL_LIMIT) begin
            tx_valid <= 1'b0;
            error    <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_tally_reporter.sv
// Directed bench for vote_tally_reporter: table-driven frames plus hand-written
// stall, timeout, busy-request and mid-frame reset sequences.
module tb_vote_tally_reporter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] vc1, vc2, vc3, vc4;
  logic       report_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic [1:0] winner;
  logic       tie;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vote_tally_reporter #(.HEADER(8'hA5), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .vc1(vc1), .vc2(vc2), .vc3(vc3), .vc4(vc4),
    .report_req(report_req),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .winner(winner), .tie(tie), .done(done), .error(error)
  );

  typedef struct packed {
    logic [3:0][7:0] vc;
    logic [6:0][7:0] b;
    logic [1:0]      win;
    logic            tie;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] c1, c2, c3, c4, st, ck,
                              input logic [1:0] w, input logic t);
    vec_t v;
    v.vc  = {c4, c3, c2, c1};
    v.b   = {ck, st, c4, c3, c2, c1, 8'hA5};
    v.win = w;
    v.tie = t;
    return v;
  endfunction

  // Requests one frame and consumes it. slow: ready 1-of-3 cycles; mutate:
  // change vc3 mid-frame; spam: pulse report_req while busy.
  task automatic run_frame(input string tag, input vec_t v,
                           input bit slow, input bit mutate, input bit spam);
    int k = 0;
    int cyc;
    int first_valid = -1;
    int done_cyc = -1;
    int err_cnt = 0;
    logic [7:0] held = 8'h00;
    bit stalled = 0;
    vc1 = v.vc[0]; vc2 = v.vc[1]; vc3 = v.vc[2]; vc4 = v.vc[3];
    @(negedge clk);
    report_req = 1'b1;
    tx_ready   = 1'b0;
    @(negedge clk);
    report_req = 1'b0;
    cyc = 1;
    while (cyc < 200 && done_cyc < 0) begin
      if (done)  done_cyc = cyc;
      if (error) err_cnt++;
      if (tx_valid && first_valid < 0) first_valid = cyc;
      if (stalled) begin
        check({tag, " stall_hold"}, {tx_valid, tx_data}, {1'b1, held});
        stalled = 0;
      end
      tx_ready = slow ? (cyc % 3 == 0) : 1'b1;
      if (spam) report_req = (cyc % 3 == 0);
      if (mutate && k == 3) vc3 = 8'd99;
      if (tx_valid) begin
        if (tx_ready) begin
          if (k < 7) check($sformatf("%s byte%0d", tag, k), tx_data, v.b[k]);
          k++;
        end else begin
          held    = tx_data;
          stalled = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    report_req = 1'b0;
    tx_ready   = 1'b0;
    check({tag, " done_seen"}, done_cyc >= 0, 1);
    check({tag, " byte_count"}, k, 7);
    if (!slow) begin
      check({tag, " first_valid_lat"}, first_valid, 2);
      check({tag, " done_lat"}, done_cyc, 9);
    end
    check({tag, " done_pulse_len"}, done, 0);
    check({tag, " winner"}, winner, v.win);
    check({tag, " tie"}, tie, v.tie);
    check({tag, " no_error"}, err_cnt, 0);
    if (spam) begin
      repeat (3) @(negedge clk);
      check({tag, " no_second_frame"}, {busy, tx_valid}, 2'b00);
    end
  endtask

  initial begin
    int stalls;
    bit seen;
    reset = 1'b0; report_req = 1'b0; tx_ready = 1'b0;
    vc1 = 8'd0; vc2 = 8'd0; vc3 = 8'd0; vc4 = 8'd0;

    vecs[0] = mk(8'd3,   8'd7,  8'd7,   8'd1,   8'h81, 8'h26, 2'd1, 1'b1);
    vecs[1] = mk(8'd10,  8'd20, 8'd30,  8'd5,   8'h02, 8'hA2, 2'd2, 1'b0);
    vecs[2] = mk(8'd0,   8'd0,  8'd0,   8'd0,   8'h80, 8'h25, 2'd0, 1'b1);
    vecs[3] = mk(8'd255, 8'd0,  8'd255, 8'd255, 8'h80, 8'hDA, 2'd0, 1'b1);
    vecs[4] = mk(8'd1,   8'd2,  8'd3,   8'd200, 8'h03, 8'h6E, 2'd3, 1'b0);

    @(negedge clk);
    check("reset_outputs", {tx_data, tx_valid, busy, winner, tie, done, error}, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, tx_valid}, 2'b00);

    for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), vecs[i], 0, 0, 0);

    run_frame("slow_mutate", vecs[1], 1, 1, 0);
    run_frame("busy_req", vecs[0], 0, 0, 1);

    // Timeout: three bytes accepted, then the sink stalls for good.
    vc1 = 8'd10; vc2 = 8'd20; vc3 = 8'd30; vc4 = 8'd5;
    @(negedge clk);
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    tx_ready   = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    tx_ready = 1'b0;
    stalls = 0;
    seen   = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (error) seen = 1;
      else begin
        if (tx_valid && !tx_ready) stalls++;
        @(negedge clk);
      end
    end
    check("timeout_error_seen", seen, 1);
    check("timeout_stall_cycles", stalls, 4);
    check("timeout_outputs", {tx_valid, busy}, 2'b00);
    @(negedge clk);
    check("timeout_error_pulse", error, 0);
    run_frame("after_timeout", vecs[1], 0, 0, 0);

    // Reset while byte 3 is on the bus.
    vc1 = 8'd10; vc2 = 8'd20; vc3 = 8'd30; vc4 = 8'd5;
    @(negedge clk);
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    tx_ready   = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_reset_byte3", {tx_valid, tx_data}, {1'b1, 8'd30});
    #2 reset = 1'b0;
    #1 check("mid_reset_outputs", {tx_data, tx_valid, busy, winner, tie, done, error}, '0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || error || tx_valid || busy) seen = 1;
    end
    check("post_reset_quiet", seen, 0);
    run_frame("after_reset", vecs[2], 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
